hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/load_use_detect.sv | 13 +
 rtl/hazard_control_unit.sv | 108 ++++++++++
 tb/tb_hazard_control_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, hazard FSM states and pipeline latch control bundles.
package cpu_types_pkg;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} hazard_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctl_t;

  typedef struct packed {
    logic       pc_en;
    latch_ctl_t ifid;
    latch_ctl_t idex;
    latch_ctl_t exmem;
    latch_ctl_t memwb;
  } hazard_ctl_t;

  // Bit order: pc_en, then {en,flush} for ifid, idex, exmem, memwb.
  localparam hazard_ctl_t CTL_ADVANCE = hazard_ctl_t'(9'b1_10_10_10_10);
  localparam hazard_ctl_t CTL_RESET   = hazard_ctl_t'(9'b0_11_11_11_11);
  localparam hazard_ctl_t CTL_FROZEN  = hazard_ctl_t'(9'b0_00_00_00_00);
  localparam hazard_ctl_t CTL_MEMWAIT = hazard_ctl_t'(9'b0_00_00_00_11);
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a load in EX writing a register the ID instruction reads.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     memtoreg,
  input  regbits_t wsel,
  input  regbits_t rs,
  input  regbits_t rt,
  output logic     stall
);
  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign stall = memtoreg && (wsel != '0) && ((wsel == rs) || (wsel == rt));
endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller (RUN/MEMWAIT/HALTED). Define HAZARD_STALL_CNT_EN to add
// the saturating stall_cnt output.
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     ihit,
  input  logic     dhit,
  input  logic     dREN_MEM,
  input  logic     dWEN_MEM,
  input  logic     memtoReg_EX,
  input  regbits_t wsel_EX,
  input  regbits_t rs_ID,
  input  regbits_t rt_ID,
  input  logic     redirect_EX,
  input  logic     halt_MEM,
  output logic     pc_en,
  output logic     ifid_enable,
  output logic     ifid_flush,
  output logic     idex_enable,
  output logic     idex_flush,
  output logic     exmem_enable,
  output logic     exmem_flush,
  output logic     memwb_enable,
  output logic     memwb_flush,
  output logic     halted
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);
  hazard_state_t state, state_nxt;
  hazard_ctl_t   ctl;
  logic          load_use, mem_wait;

  load_use_detect u_lud (
    .memtoreg (memtoReg_EX),
    .wsel     (wsel_EX),
    .rs       (rs_ID),
    .rt       (rt_ID),
    .stall    (load_use)
  );

  // MEMWAIT keeps waiting on its own even if the MEM request lines drop.
  assign mem_wait = ((dREN_MEM || dWEN_MEM) && !dhit) || ((state == MEMWAIT) && !dhit);

  always_comb begin
    ctl       = CTL_ADVANCE;
    state_nxt = RUN;
    if (RST) begin
      ctl = CTL_RESET;
    end else if (state == HALTED) begin
      ctl       = CTL_FROZEN;
      state_nxt = HALTED;
    end else if (mem_wait) begin
      ctl       = CTL_MEMWAIT;
      state_nxt = MEMWAIT;
    end else begin
      if (redirect_EX) begin
        ctl.ifid.flush = 1'b1;
        ctl.idex.flush = 1'b1;
      end else if (load_use) begin
        ctl.pc_en      = 1'b0;
        ctl.ifid.en    = 1'b0;
        ctl.idex.flush = 1'b1;
      end else if (!ihit) begin
        ctl.pc_en      = 1'b0;
        ctl.ifid.flush = 1'b1;
      end
      // The halt itself retires; nothing behind it may enter MEM/WB.
      if (halt_MEM) begin
        ctl.exmem.flush = 1'b1;
        state_nxt       = HALTED;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  assign pc_en        = ctl.pc_en;
  assign ifid_enable  = ctl.ifid.en;
  assign ifid_flush   = ctl.ifid.flush;
  assign idex_enable  = ctl.idex.en;
  assign idex_flush   = ctl.idex.flush;
  assign exmem_enable = ctl.exmem.en;
  assign exmem_flush  = ctl.exmem.flush;
  assign memwb_enable = ctl.memwb.en;
  assign memwb_flush  = ctl.memwb.flush;
  assign halted       = (state == HALTED);

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST)
      stall_cnt <= '0;
    else if ((state != HALTED) && !ctl.pc_en && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  logic unused_cnt_cfg;
  assign unused_cnt_cfg = |STALL_CNT_W;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized + directed bench for hazard_control_unit against a rule-level reference model.
module tb_hazard_control_unit;
  import cpu_types_pkg::*;
  localparam int CW = 8;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX, redirect_EX, halt_MEM;
  logic [4:0] wsel_EX, rs_ID, rt_ID;
  logic pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic exmem_enable, exmem_flush, memwb_enable, memwb_flush, halted;
`ifdef HAZARD_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  int n_chk = 0, n_err = 0;
  bit m_halt, m_wait;
  int m_cnt;

  always #5 CLK = ~CLK;

  hazard_control_unit #(.STALL_CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN_MEM(dREN_MEM), .dWEN_MEM(dWEN_MEM),
    .memtoReg_EX(memtoReg_EX), .wsel_EX(wsel_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .redirect_EX(redirect_EX), .halt_MEM(halt_MEM), .pc_en(pc_en),
    .ifid_enable(ifid_enable), .ifid_flush(ifid_flush), .idex_enable(idex_enable),
    .idex_flush(idex_flush), .exmem_enable(exmem_enable), .exmem_flush(exmem_flush),
    .memwb_enable(memwb_enable), .memwb_flush(memwb_flush), .halted(halted)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {pc_en, ifid en/flush, idex en/flush, exmem en/flush, memwb en/flush}.
  function automatic logic [8:0] exp_ctl();
    logic lu;
    logic [8:0] v;
    if (RST) return 9'b0_11_11_11_11;
    if (m_halt) return 9'b0_00_00_00_00;
    if (((dREN_MEM || dWEN_MEM) && !dhit) || (m_wait && !dhit)) return 9'b0_00_00_00_11;
    lu = memtoReg_EX && (wsel_EX != 0) && (wsel_EX == rs_ID || wsel_EX == rt_ID);
    if (redirect_EX)  v = 9'b1_11_11_10_10;
    else if (lu)      v = 9'b0_00_11_10_10;
    else if (!ihit)   v = 9'b0_11_10_10_10;
    else              v = 9'b1_10_10_10_10;
    if (halt_MEM) v[2] = 1'b1;
    return v;
  endfunction

  task automatic idle();
    RST = 0; ihit = 1; dhit = 0; dREN_MEM = 0; dWEN_MEM = 0; memtoReg_EX = 0;
    wsel_EX = 0; rs_ID = 0; rt_ID = 0; redirect_EX = 0; halt_MEM = 0;
  endtask

  // Check this cycle's outputs, then advance the model across the clock edge.
  task automatic tick(string tag);
    logic [8:0] e;
    bit mw;
    #2;
    e = exp_ctl();
    check(tag, {pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush,
                exmem_enable, exmem_flush, memwb_enable, memwb_flush}, 32'(e));
    check({tag, ".halted"}, 32'(halted), 32'(m_halt));
`ifdef HAZARD_STALL_CNT_EN
    check({tag, ".cnt"}, 32'(stall_cnt), 32'(m_cnt));
`endif
    mw = ((dREN_MEM || dWEN_MEM) && !dhit) || (m_wait && !dhit);
    @(posedge CLK);
    if (RST) begin
      m_halt = 0; m_wait = 0; m_cnt = 0;
    end else if (!m_halt) begin
      if (!e[8] && m_cnt < (1 << CW) - 1) m_cnt++;
      m_wait = mw;
      if (!mw && halt_MEM) m_halt = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); RST = 1;
    tick("reset"); tick("reset");
    RST = 0;
  endtask

  initial begin
    idle(); RST = 1;
    @(posedge CLK); #1;
    m_halt = 0; m_wait = 0; m_cnt = 0;
    do_reset();
    tick("idle");

    // load-use on rs, then the same pattern against r0
    memtoReg_EX = 1; wsel_EX = 5; rs_ID = 5; rt_ID = 2;
    tick("lu_rs");
    check("lu_rs.pc", 32'(pc_en), 0);
    memtoReg_EX = 0; tick("lu_clear");
    memtoReg_EX = 1; wsel_EX = 0; rs_ID = 0; tick("lu_r0");
    check("lu_r0.pc", 32'(pc_en), 1);
    wsel_EX = 9; rs_ID = 1; rt_ID = 9; tick("lu_rt");

    // 3-cycle data miss, then hit
    do_reset(); idle();
    dREN_MEM = 1;
    for (int i = 0; i < 3; i++) begin
      tick("memwait");
      check("memwait.bubble", {memwb_enable, memwb_flush}, 2'b11);
    end
    dhit = 1; tick("memwait_hit");
`ifdef HAZARD_STALL_CNT_EN
    check("memwait.cnt3", 32'(stall_cnt), 3);
`endif
    idle(); tick("after_mem");

    // MEMWAIT persists with request dropped; redirect held through it fires on dhit
    dWEN_MEM = 1; tick("st_miss");
    dWEN_MEM = 0; redirect_EX = 1; tick("wait_held");
    dhit = 1; memtoReg_EX = 1; wsel_EX = 3; rs_ID = 3; tick("redir_lu");
    check("redir_lu.flush", {ifid_flush, idex_flush, pc_en}, 3'b111);
    idle(); tick("idle2");

    // halt, then toggling hit lines cannot wake it
    halt_MEM = 1; tick("halt");
    halt_MEM = 0;
    for (int i = 0; i < 4; i++) begin
      ihit = i[0]; dhit = i[1]; dREN_MEM = 1; tick("halted");
      check("halted.const", 32'(halted), 1);
    end
    idle(); RST = 1; tick("halt_rst");
    RST = 0; tick("post_halt");
    check("post_halt.run", 32'(halted), 0);

    // reset abandons a pending data wait
    dREN_MEM = 1; tick("miss_pre_rst");
    dREN_MEM = 0; RST = 1; tick("rst_in_wait");
    RST = 0; tick("rst_left_wait");
    check("rst_left_wait.pc", 32'(pc_en), 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(0, 39) == 0);
      ihit = ($urandom_range(0, 3) != 0);
      dhit = $urandom_range(0, 1);
      dREN_MEM = ($urandom_range(0, 3) == 0);
      dWEN_MEM = ($urandom_range(0, 5) == 0);
      memtoReg_EX = $urandom_range(0, 1);
      wsel_EX = 5'($urandom_range(0, 3));
      rs_ID = 5'($urandom_range(0, 3));
      rt_ID = 5'($urandom_range(0, 3));
      redirect_EX = ($urandom_range(0, 4) == 0);
      halt_MEM = ($urandom_range(0, 49) == 0);
      tick("rand");
    end

    // counter saturation on a long fetch miss
    do_reset(); idle(); ihit = 0;
    for (int i = 0; i < 260; i++) tick("sat");
`ifdef HAZARD_STALL_CNT_EN
    check("sat.max", 32'(stall_cnt), (1 << CW) - 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
